// File: rtl/cnn_layer_accel_ctrl_pkg.sv
// Shared types and constants for the cnn_layer_accel quad job sequencer.
package cnn_layer_accel_ctrl_pkg;

  localparam int C_QUAD_DATA_W = 128;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CFG,
    S_JSTART,
    S_WFETCH,
    S_FACK,
    S_STREAM,
    S_FDONE,
    S_WCOMP,
    S_DONE
  } state_e;

endpackage

// File: rtl/cnn_layer_accel_prefetch_fifo.sv
// 2-entry first-word-fall-through skid FIFO fed by a 1-cycle-latency RAM.
// The in-flight flag reserves a slot for every read so the FIFO can never overflow.
module cnn_layer_accel_prefetch_fifo
  import cnn_layer_accel_ctrl_pkg::*;
#(
  parameter int DW = C_QUAD_DATA_W
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          issue_i,
  input  logic [DW-1:0] rd_data_i,
  input  logic          pop_i,
  output logic          can_issue_o,
  output logic          head_valid_o,
  output logic [DW-1:0] head_data_o
);

  logic [DW-1:0] mem_q [2];
  logic          wr_idx_q;
  logic          rd_idx_q;
  logic [1:0]    count_q;
  logic          inflight_q;
  logic          wr;
  logic          pop;

  assign head_valid_o = (count_q != 2'd0);
  assign head_data_o  = mem_q[rd_idx_q];
  assign wr           = inflight_q;
  assign pop          = pop_i && head_valid_o;
  // A slot freed by this cycle's pop can be reused, which keeps back-to-back streaming.
  assign can_issue_o  = (3'(count_q) + 3'(inflight_q)) < (3'd2 + 3'(pop));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_idx_q   <= 1'b0;
      rd_idx_q   <= 1'b0;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
    end else if (flush_i) begin
      wr_idx_q   <= 1'b0;
      rd_idx_q   <= 1'b0;
      count_q    <= 2'd0;
      inflight_q <= issue_i;
    end else begin
      inflight_q <= issue_i;
      if (wr) begin
        mem_q[wr_idx_q] <= rd_data_i;
        wr_idx_q        <= ~wr_idx_q;
      end
      if (pop) rd_idx_q <= ~rd_idx_q;
      count_q <= count_q + 2'(wr) - 2'(pop);
    end
  end

endmodule

// File: rtl/cnn_layer_accel_job_ctrl.sv
// Host-side job sequencer: loads a quad's sequence table, then streams one pixel row per fetch request.
// The config and pixel paths share one prefetch FIFO, selected by the FSM state.
module cnn_layer_accel_job_ctrl
  import cnn_layer_accel_ctrl_pkg::*;
#(
  parameter int C_PIXEL_WIDTH = 16,
  parameter int C_NUM_LANES   = 8,
  parameter int C_CFG_WORDS   = 512,
  parameter int C_PIX_ADDR_W  = 16,
  parameter int C_DIM_W       = 10
) (
  input  logic                                 clk_if,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [C_DIM_W-1:0]                   num_rows,
  input  logic [C_DIM_W-1:0]                   num_cols,
  input  logic [1:0]                           cfg_quad_sel,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err,
  output logic [$clog2(C_CFG_WORDS)-1:0]       cfg_rd_addr,
  input  logic [C_QUAD_DATA_W-1:0]             cfg_rd_data,
  output logic [C_PIX_ADDR_W-1:0]              pix_rd_addr,
  output logic                                 pix_rd_en,
  input  logic [C_PIXEL_WIDTH*C_NUM_LANES-1:0] pix_rd_data,
  output logic [3:0]                           config_valid,
  input  logic [3:0]                           config_accept,
  output logic [C_QUAD_DATA_W-1:0]             config_data,
  output logic                                 job_start,
  input  logic                                 job_accept,
  input  logic                                 job_fetch_request,
  output logic                                 job_fetch_ack,
  output logic                                 job_fetch_complete,
  input  logic                                 job_complete,
  output logic                                 job_complete_ack,
  output logic                                 pixel_valid,
  input  logic                                 pixel_ready,
  output logic [C_PIXEL_WIDTH*C_NUM_LANES-1:0] pixel_data
);

  localparam int              CAW      = $clog2(C_CFG_WORDS);
  localparam logic [CAW:0]    CFG_END  = (CAW+1)'(C_CFG_WORDS);
  localparam logic [CAW-1:0]  CFG_LAST = CAW'(C_CFG_WORDS - 1);

  state_e                    state_q, state_d;
  logic [C_DIM_W-1:0]        rows_left_q, rows_left_d;
  logic [C_DIM_W-1:0]        cols_q, cols_d;
  logic [C_DIM_W-1:0]        col_cnt_q, col_cnt_d;
  logic [C_DIM_W-1:0]        pix_iss_q, pix_iss_d;
  logic [C_PIX_ADDR_W-1:0]   pix_ptr_q, pix_ptr_d;
  logic [CAW:0]              cfg_iss_q, cfg_iss_d;
  logic [CAW-1:0]            cfg_xfer_q, cfg_xfer_d;
  logic                      err_q, err_d;

  logic                      dims_ok, start_ok, cfg_issue, cfg_xfer, pix_beat;
  logic                      can_issue, head_valid;
  logic [C_QUAD_DATA_W-1:0]  head_data, fifo_rdata;

  assign dims_ok   = (num_rows != '0) && (num_cols != '0);
  assign start_ok  = (state_q == S_IDLE) && start && dims_ok;
  assign cfg_xfer  = (state_q == S_CFG) && head_valid && config_accept[cfg_quad_sel];
  assign pix_beat  = (state_q == S_STREAM) && head_valid && pixel_ready;
  // Word 0 is requested on the start cycle itself so it is presented two cycles later.
  assign cfg_issue = start_ok || ((state_q == S_CFG) && (cfg_iss_q != CFG_END) && can_issue);
  assign pix_rd_en = ((state_q == S_FACK) || (state_q == S_STREAM)) && (pix_iss_q != cols_q) && can_issue;
  assign fifo_rdata = (state_q == S_CFG) ? cfg_rd_data : pix_rd_data;

  cnn_layer_accel_prefetch_fifo #(.DW(C_QUAD_DATA_W)) u_fifo (
    .clk_i        (clk_if),
    .rst_i        (rst),
    .flush_i      (start_ok),
    .issue_i      (cfg_issue || pix_rd_en),
    .rd_data_i    (fifo_rdata),
    .pop_i        (cfg_xfer || pix_beat),
    .can_issue_o  (can_issue),
    .head_valid_o (head_valid),
    .head_data_o  (head_data)
  );

  always_comb begin
    state_d     = state_q;
    rows_left_d = rows_left_q;
    cols_d      = cols_q;
    col_cnt_d   = col_cnt_q;
    pix_iss_d   = pix_iss_q;
    pix_ptr_d   = pix_ptr_q;
    cfg_iss_d   = cfg_iss_q;
    cfg_xfer_d  = cfg_xfer_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: if (start) begin
        if (dims_ok) begin
          state_d     = S_CFG;
          rows_left_d = num_rows;
          cols_d      = num_cols;
          col_cnt_d   = '0;
          pix_iss_d   = '0;
          pix_ptr_d   = '0;
          cfg_iss_d   = (CAW+1)'(1);
          cfg_xfer_d  = '0;
          err_d       = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end
      S_CFG: if (cfg_xfer) begin
        cfg_xfer_d = cfg_xfer_q + 1'b1;
        if (cfg_xfer_q == CFG_LAST) state_d = S_JSTART;
      end
      S_JSTART: if (job_accept) state_d = S_WFETCH;
      S_WFETCH: begin
        if (job_fetch_request) begin
          if (rows_left_q != '0) state_d = S_FACK;
          else                   err_d   = 1'b1;
        end else if (job_complete && (rows_left_q == '0)) begin
          state_d = S_WCOMP;
        end
      end
      S_FACK: state_d = S_STREAM;
      S_STREAM: if (pix_beat) begin
        col_cnt_d = col_cnt_q + 1'b1;
        if (col_cnt_q == cols_q - 1'b1) state_d = S_FDONE;
      end
      S_FDONE: begin
        rows_left_d = rows_left_q - 1'b1;
        col_cnt_d   = '0;
        pix_iss_d   = '0;
        state_d     = (rows_left_q == C_DIM_W'(1)) ? S_WCOMP : S_WFETCH;
      end
      S_WCOMP: begin
        if (job_fetch_request) err_d = 1'b1;
        if (job_complete) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if ((state_q == S_CFG) && cfg_issue) cfg_iss_d = cfg_iss_q + 1'b1;
    if (pix_rd_en) begin
      pix_iss_d = pix_iss_q + 1'b1;
      pix_ptr_d = pix_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_if or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rows_left_q <= '0;
      cols_q      <= '0;
      col_cnt_q   <= '0;
      pix_iss_q   <= '0;
      pix_ptr_q   <= '0;
      cfg_iss_q   <= '0;
      cfg_xfer_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_left_q <= rows_left_d;
      cols_q      <= cols_d;
      col_cnt_q   <= col_cnt_d;
      pix_iss_q   <= pix_iss_d;
      pix_ptr_q   <= pix_ptr_d;
      cfg_iss_q   <= cfg_iss_d;
      cfg_xfer_q  <= cfg_xfer_d;
      err_q       <= err_d;
    end
  end

  // Outputs decode from state so an async reset drops every handshake at once.
  assign busy               = (state_q != S_IDLE);
  assign done               = (state_q == S_DONE);
  assign err                = err_q;
  assign cfg_rd_addr        = (state_q == S_CFG) ? cfg_iss_q[CAW-1:0] : '0;
  assign pix_rd_addr        = pix_ptr_q;
  assign config_valid       = ((state_q == S_CFG) && head_valid) ? (4'b0001 << cfg_quad_sel) : 4'b0000;
  assign config_data        = ((state_q == S_CFG) && head_valid) ? head_data : '0;
  assign job_start          = (state_q == S_JSTART);
  assign job_fetch_ack      = (state_q == S_FACK);
  assign job_fetch_complete = (state_q == S_FDONE);
  assign job_complete_ack   = (state_q == S_WCOMP) && job_complete;
  assign pixel_valid        = (state_q == S_STREAM) && head_valid;
  assign pixel_data         = pixel_valid ? head_data : '0;

endmodule

// File: tb/tb_cnn_layer_accel_job_ctrl.sv
// Directed bench for the quad job sequencer: config load, row streaming, error cases, mid-stream reset.
module tb_cnn_layer_accel_job_ctrl;

  logic         clk_if = 1'b0;
  logic         rst;
  logic         start;
  logic [9:0]   num_rows, num_cols;
  logic [1:0]   cfg_quad_sel;
  logic         busy, done, err;
  logic [8:0]   cfg_rd_addr;
  logic [127:0] cfg_rd_data;
  logic [15:0]  pix_rd_addr;
  logic         pix_rd_en;
  logic [127:0] pix_rd_data;
  logic [3:0]   config_valid, config_accept;
  logic [127:0] config_data;
  logic         job_start, job_accept, job_fetch_request, job_fetch_ack, job_fetch_complete;
  logic         job_complete, job_complete_ack, pixel_valid, pixel_ready;
  logic [127:0] pixel_data;

  int n_chk = 0;
  int n_err = 0;
  int js_cnt, acks, fcs, beats, data_err, stab_err, cacks, dones, lat, aborted;

  always #5 clk_if = ~clk_if;

  cnn_layer_accel_job_ctrl dut (
    .clk_if(clk_if), .rst(rst), .start(start), .num_rows(num_rows), .num_cols(num_cols),
    .cfg_quad_sel(cfg_quad_sel), .busy(busy), .done(done), .err(err),
    .cfg_rd_addr(cfg_rd_addr), .cfg_rd_data(cfg_rd_data),
    .pix_rd_addr(pix_rd_addr), .pix_rd_en(pix_rd_en), .pix_rd_data(pix_rd_data),
    .config_valid(config_valid), .config_accept(config_accept), .config_data(config_data),
    .job_start(job_start), .job_accept(job_accept),
    .job_fetch_request(job_fetch_request), .job_fetch_ack(job_fetch_ack),
    .job_fetch_complete(job_fetch_complete),
    .job_complete(job_complete), .job_complete_ack(job_complete_ack),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .pixel_data(pixel_data)
  );

  function automatic logic [127:0] cfg_word(input int i);
    return {32'(i) ^ 32'hC0DE_0000, ~32'(i), 32'(i * 3 + 5), 32'h1234_5678 + 32'(i)};
  endfunction

  function automatic logic [127:0] pix_word(input int a);
    return {32'(a * 7 + 1), 32'hA5A5_0000 | 32'(a), ~32'(a), 32'(a) ^ 32'h0000_5A5A};
  endfunction

  // Config and pixel memories, one-cycle read latency.
  always @(posedge clk_if) begin
    cfg_rd_data <= cfg_word(int'(cfg_rd_addr));
    pix_rd_data <= pix_word(int'(pix_rd_addr));
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input int rows, input int cols, input int sel);
    @(negedge clk_if);
    num_rows     = 10'(rows);
    num_cols     = 10'(cols);
    cfg_quad_sel = 2'(sel);
    start        = 1'b1;
    @(negedge clk_if);
    start = 1'b0;
    #1;
  endtask

  task automatic run_cfg(input int sel, input int mode);
    int idx = 0, cyc = 0, first = -1, last = -1, derr = 0, herr = 0, serr = 0;
    logic prev_stall = 1'b0;
    logic [127:0] prev = '0;
    logic v, acc;
    while (idx < 512 && cyc < 4000) begin
      @(negedge clk_if);
      cyc++;
      acc = (mode == 0) || (cyc % 3 == 0);
      config_accept = acc ? (4'b0001 << sel) : 4'b0000;
      #1;
      v = config_valid[sel];
      if ((config_valid & ~(4'b0001 << sel)) != 4'b0000) herr++;
      if (prev_stall && (!v || config_data !== prev)) serr++;
      if (v && first < 0) first = cyc;
      if (v && acc) begin
        if (config_data !== cfg_word(idx)) derr++;
        idx++;
        last = cyc;
      end
      prev_stall = v && !acc;
      prev       = config_data;
    end
    chk("cfg_word_count", 128'(idx), 128'(512));
    chk("cfg_data_order", 128'(derr), 128'(0));
    chk("cfg_valid_onehot", 128'(herr), 128'(0));
    chk("cfg_stall_stable", 128'(serr), 128'(0));
    if (mode == 0) begin
      chk("cfg_first_latency", 128'(first), 128'(1));
      chk("cfg_back_to_back", 128'(last - first + 1), 128'(512));
    end
  endtask

  task automatic run_job(input int rows, input int rmode, input int extra, input int abort_at);
    int cyc = 0, xcnt = 0, first_ack = -1, first_v = -1;
    logic want_req = 1'b1, want_comp = 1'b0, fin = 1'b0, prev_stall = 1'b0;
    logic [127:0] prev = '0;
    js_cnt = 0; acks = 0; fcs = 0; beats = 0; data_err = 0; stab_err = 0;
    cacks = 0; dones = 0; aborted = 0;
    while (!fin && cyc < 3000) begin
      @(negedge clk_if);
      cyc++;
      config_accept     = 4'b0000;
      pixel_ready       = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      job_accept        = job_start;
      job_fetch_request = want_req;
      job_complete      = want_comp;
      #1;
      if (job_start) js_cnt++;
      if (job_fetch_ack) begin
        acks++;
        if (first_ack < 0) first_ack = cyc;
        want_req = 1'b0;
      end
      if (prev_stall && (!pixel_valid || pixel_data !== prev)) stab_err++;
      if (pixel_valid && first_v < 0) first_v = cyc;
      if (pixel_valid && pixel_ready) begin
        if (pixel_data !== pix_word(beats)) data_err++;
        beats++;
      end
      prev_stall = pixel_valid && !pixel_ready;
      prev       = pixel_data;
      if (job_fetch_complete) begin
        fcs++;
        if (fcs < rows) want_req = 1'b1;
      end
      if (fcs == rows && !want_comp && cacks == 0) begin
        if (extra != 0 && xcnt < 4) begin
          want_req = 1'b1;
          xcnt++;
        end else begin
          want_req  = 1'b0;
          want_comp = 1'b1;
        end
      end
      if (job_complete_ack) begin
        cacks++;
        want_comp = 1'b0;
      end
      if (done) begin
        dones++;
        fin = 1'b1;
      end
      if (abort_at > 0 && beats == abort_at) begin
        rst = 1'b1;
        #1;
        aborted = 1;
        fin = 1'b1;
      end
    end
    job_fetch_request = 1'b0;
    job_complete      = 1'b0;
    job_accept        = 1'b0;
    lat = first_v - first_ack;
  endtask

  task automatic check_full_job(input string tag);
    chk({tag, "_job_start_cycles"}, 128'(js_cnt), 128'(1));
    chk({tag, "_fetch_acks"}, 128'(acks), 128'(10));
    chk({tag, "_fetch_completes"}, 128'(fcs), 128'(10));
    chk({tag, "_beats"}, 128'(beats), 128'(100));
    chk({tag, "_pixel_data"}, 128'(data_err), 128'(0));
    chk({tag, "_pixel_stall_stable"}, 128'(stab_err), 128'(0));
    chk({tag, "_complete_acks"}, 128'(cacks), 128'(1));
    chk({tag, "_done_pulses"}, 128'(dones), 128'(1));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_rows = '0; num_cols = '0; cfg_quad_sel = '0;
    config_accept = '0; job_accept = 1'b0; job_fetch_request = 1'b0;
    job_complete = 1'b0; pixel_ready = 1'b0;
    repeat (3) @(negedge clk_if);
    #1;
    chk("reset_ctrl_outputs", 128'({busy, done, err, cfg_rd_addr, pix_rd_addr, pix_rd_en, config_valid,
        job_start, job_fetch_ack, job_fetch_complete, job_complete_ack, pixel_valid}), 128'(0));
    chk("reset_data_outputs", config_data | pixel_data, 128'(0));
    rst = 1'b0;

    // Zero column count: error, stays idle
    do_start(10, 0, 0);
    chk("zero_dim_err", 128'(err), 128'(1));
    chk("zero_dim_busy", 128'(busy), 128'(0));
    @(negedge clk_if); #1;
    chk("zero_dim_still_idle", 128'({busy, config_valid}), 128'(0));

    // Full config load with accept held, then a 10x10 job with ready held
    do_start(10, 10, 0);
    chk("start_clears_err", 128'(err), 128'(0));
    chk("start_busy", 128'(busy), 128'(1));
    chk("cfg_valid_not_yet", 128'(config_valid), 128'(0));
    run_cfg(0, 0);
    run_job(10, 0, 0, 0);
    check_full_job("t3");
    chk("t3_fack_to_valid", 128'(lat), 128'(2));
    chk("t3_err", 128'(err), 128'(0));
    @(negedge clk_if); #1;
    chk("t3_back_idle", 128'({busy, done}), 128'(0));

    // Throttled config accept on quad 2, random pixel ready, extra fetch request after the last row
    do_start(10, 10, 2);
    run_cfg(2, 1);
    run_job(10, 1, 1, 0);
    check_full_job("t4");
    chk("t5_extra_req_err", 128'(err), 128'(1));
    @(negedge clk_if); #1;
    chk("t5_err_sticky", 128'({busy, err}), 128'(1));

    // Reset mid-stream at beat 37, then a clean rerun
    do_start(10, 10, 1);
    chk("t6_start_clears_err", 128'(err), 128'(0));
    run_cfg(1, 0);
    run_job(10, 0, 0, 37);
    chk("t6_aborted", 128'(aborted), 128'(1));
    chk("t6_abort_ctrl_outputs", 128'({busy, done, err, cfg_rd_addr, pix_rd_addr, pix_rd_en, config_valid,
        job_start, job_fetch_ack, job_fetch_complete, job_complete_ack, pixel_valid}), 128'(0));
    chk("t6_abort_data_outputs", config_data | pixel_data, 128'(0));
    @(negedge clk_if);
    rst = 1'b0;
    do_start(10, 10, 3);
    run_cfg(3, 0);
    run_job(10, 0, 0, 0);
    check_full_job("t6_rerun");
    chk("t6_rerun_fack_to_valid", 128'(lat), 128'(2));
    chk("t6_rerun_err", 128'(err), 128'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
